acia_fifo_uart: RTL and testbench

- 6551-register-compatible ACIA with parametrised RX/TX FIFOs, 16x-oversampled receiver, level-based RX interrupt and a 16-entry baud table extended with 115200.
- Slot cards (serial, MIDI, modem) instantiate it behind their device-select decode; the host sees the four standard 6551 registers.
- The core performs the ROM/DIP mapping; the card only qualifies cs_i.

---
 rtl/acia_fifo_uart_if.sv | 20 ++
 rtl/acia_fifo_uart.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_acia_fifo_uart.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acia_fifo_uart_if.sv
// Host bus of the ACIA: strobe, select, register address, data, IRQ.
// master = host/card side, slave = ACIA core.
interface acia_fifo_uart_if;
    logic       ph2_i;
    logic       cs_i;
    logic       rw_n_i;
    logic [1:0] rs_i;
    logic [7:0] data_i;
    logic [7:0] data_o;
    logic       irq_n_o;

    modport master (
        output ph2_i, cs_i, rw_n_i, rs_i, data_i,
        input  data_o, irq_n_o
    );
    modport slave (
        input  ph2_i, cs_i, rw_n_i, rs_i, data_i,
        output data_o, irq_n_o
    );
endinterface

// File: rtl/acia_fifo_uart.sv
// 6551-compatible ACIA, RX/TX FIFOs, 16x receiver, 8N1 only.
// Ports: clk_logic_i, reset_n (sync, active low), bus (host regs),
//   rxd_i/txd_o serial, cts/dcd/dsr in, rts/dtr out, FIFO levels.
// Option: ACIA_AUTO_FLOW_EN enables RTS/CTS hardware flow control.
module acia_fifo_uart #(
    parameter int CLOCK_SPEED_HZ = 54_000_000,
    parameter int RX_DEPTH       = 16,
    parameter int TX_DEPTH       = 16,
    parameter int RX_IRQ_LEVEL   = 1
) (
    input  logic                      clk_logic_i,
    input  logic                      reset_n,
    acia_fifo_uart_if.slave           bus,
    input  logic                      rxd_i,
    output logic                      txd_o,
    input  logic                      cts_n_i,
    input  logic                      dcd_n_i,
    input  logic                      dsr_n_i,
    output logic                      rts_n_o,
    output logic                      dtr_n_o,
    output logic [$clog2(RX_DEPTH):0] rx_level_o,
    output logic [$clog2(TX_DEPTH):0] tx_level_o
);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RCW = RAW + 1;
    localparam int TCW = TAW + 1;

    function automatic int dv(input int b);
        int d;
        d = (CLOCK_SPEED_HZ + 8 * b) / (16 * b);
        return (d < 1) ? 1 : d;
    endfunction

    localparam int DIVS [16] = '{
        dv(115200), dv(50),   dv(75),   dv(110),
        dv(135),    dv(150),  dv(300),  dv(600),
        dv(1200),   dv(1800), dv(2400), dv(3600),
        dv(4800),   dv(7200), dv(9600), dv(19200)
    };
    localparam int DW = $clog2(dv(50) + 1);

    typedef enum logic [1:0] {
        S_IDLE, S_START, S_DATA, S_STOP
    } state_t;

    logic       w_acc, w_wr, w_rd;
    logic       w_wr_dat, w_rd_dat, w_wr_sts, w_rd_sts;
    logic       w_wr_cmd, w_wr_ctl;
    logic [7:0] r_cmd, r_ctrl, r_last;
    logic       r_ovr, r_frm, r_txe;
    logic       w_irq, w_brk;

    assign w_acc    = bus.ph2_i & bus.cs_i;
    assign w_wr     = w_acc & ~bus.rw_n_i;
    assign w_rd     = w_acc & bus.rw_n_i;
    assign w_wr_dat = w_wr & (bus.rs_i == 2'd0);
    assign w_rd_dat = w_rd & (bus.rs_i == 2'd0);
    assign w_wr_sts = w_wr & (bus.rs_i == 2'd1);
    assign w_rd_sts = w_rd & (bus.rs_i == 2'd1);
    assign w_wr_cmd = w_wr & (bus.rs_i == 2'd2);
    assign w_wr_ctl = w_wr & (bus.rs_i == 2'd3);
    assign w_brk    = (r_cmd[3:2] == 2'b11);

    // 16x tick generator, restarted by control writes
    logic [DW-1:0] r_tcnt, w_div;
    logic          w_tick;
    assign w_div  = DW'(DIVS[r_ctrl[3:0]]);
    assign w_tick = (r_tcnt >= w_div - DW'(1));

    always_ff @(posedge clk_logic_i) begin
        if (!reset_n || w_wr_ctl || w_tick) r_tcnt <= '0;
        else                                r_tcnt <= r_tcnt + DW'(1);
    end

    // RX FIFO
    logic [7:0]     r_rxm [RX_DEPTH];
    logic [RAW-1:0] r_rx_wp, r_rx_rp;
    logic [RCW-1:0] r_rx_cnt;
    logic           w_rx_empty, w_rx_full, w_rx_pop;
    logic           w_rx_push, w_rx_ok;
    logic [7:0]     r_rx_sh;
    logic           r_s1, r_s2, r_s3;

    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == RCW'(RX_DEPTH));
    assign w_rx_pop   = w_rd_dat & ~w_rx_empty;
    // a pop in the same cycle frees the slot for the push
    assign w_rx_ok    = w_rx_push & (~w_rx_full | w_rx_pop);

    always_ff @(posedge clk_logic_i) begin
        if (w_rx_ok) r_rxm[r_rx_wp] <= r_rx_sh;
    end

    always_ff @(posedge clk_logic_i) begin
        if (!reset_n || w_wr_sts) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_ok)  r_rx_wp <= r_rx_wp + RAW'(1);
            if (w_rx_pop) r_rx_rp <= r_rx_rp + RAW'(1);
            unique case ({w_rx_ok, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + RCW'(1);
                2'b01:   r_rx_cnt <= r_rx_cnt - RCW'(1);
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    // TX FIFO
    logic [7:0]     r_txm [TX_DEPTH];
    logic [TAW-1:0] r_tx_wp, r_tx_rp;
    logic [TCW-1:0] r_tx_cnt;
    logic           w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;

    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == TCW'(TX_DEPTH));
    assign w_tx_push  = w_wr_dat & ~w_tx_full;

    always_ff @(posedge clk_logic_i) begin
        if (w_tx_push) r_txm[r_tx_wp] <= bus.data_i;
    end

    always_ff @(posedge clk_logic_i) begin
        if (!reset_n || w_wr_sts) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + TAW'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + TAW'(1);
            unique case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + TCW'(1);
                2'b01:   r_tx_cnt <= r_tx_cnt - TCW'(1);
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // TX FSM
    state_t     r_tx_st, w_tx_nx;
    logic [3:0] r_tx_tk;
    logic [2:0] r_tx_bit;
    logic [7:0] r_tx_sh;
    logic       w_tx_end, w_tx_go;

    assign w_tx_end = w_tick & (r_tx_tk == 4'd15);
`ifdef ACIA_AUTO_FLOW_EN
    assign w_tx_go = ~w_tx_empty & ~w_brk & ~cts_n_i;
`else
    assign w_tx_go = ~w_tx_empty & ~w_brk;
`endif

    always_comb begin
        w_tx_nx  = r_tx_st;
        w_tx_pop = 1'b0;
        txd_o    = 1'b1;
        unique case (r_tx_st)
            S_IDLE: begin
                txd_o = ~w_brk;
                if (~w_tx_empty & ~cts_n_i & ~w_brk) begin
                    w_tx_nx  = S_START;
                    w_tx_pop = 1'b1;
                end
            end
            S_START: begin
                txd_o = 1'b0;
                if (w_tx_end) w_tx_nx = S_DATA;
            end
            S_DATA: begin
                txd_o = r_tx_sh[0];
                if (w_tx_end && r_tx_bit == 3'd7) w_tx_nx = S_STOP;
            end
            S_STOP: begin
                if (w_tx_end) begin
                    w_tx_nx  = w_tx_go ? S_START : S_IDLE;
                    w_tx_pop = w_tx_go;
                end
            end
            default: w_tx_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_logic_i) begin
        if (!reset_n) begin
            r_tx_st  <= S_IDLE;
            r_tx_tk  <= '0;
            r_tx_bit <= '0;
            r_tx_sh  <= '0;
        end else begin
            r_tx_st <= w_tx_nx;
            if (w_tx_pop) begin
                r_tx_sh  <= r_txm[r_tx_rp];
                r_tx_tk  <= '0;
                r_tx_bit <= '0;
            end else begin
                if (w_tick) r_tx_tk <= r_tx_tk + 4'd1;
                if (r_tx_st == S_DATA && w_tx_end) begin
                    r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
                    r_tx_bit <= r_tx_bit + 3'd1;
                end
            end
        end
    end

    // RX FSM; tick count restarts at the detected start edge
    state_t     r_rx_st, w_rx_nx;
    logic [3:0] r_rx_tk;
    logic [2:0] r_rx_bit;
    logic       w_fall, w_rx_mid;

    assign w_fall   = r_s3 & ~r_s2;
    assign w_rx_mid = w_tick & (r_rx_tk == 4'd7);

    always_comb begin
        w_rx_nx   = r_rx_st;
        w_rx_push = 1'b0;
        unique case (r_rx_st)
            S_IDLE:  if (w_fall) w_rx_nx = S_START;
            S_START: if (w_rx_mid) w_rx_nx = r_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (w_rx_mid && r_rx_bit == 3'd7) w_rx_nx = S_STOP;
            S_STOP: begin
                if (w_rx_mid) begin
                    w_rx_push = 1'b1;
                    w_rx_nx   = S_IDLE;
                end
            end
            default: w_rx_nx = S_IDLE;
        endcase
        if (!r_cmd[0]) begin
            w_rx_nx   = S_IDLE;
            w_rx_push = 1'b0;
        end
    end

    always_ff @(posedge clk_logic_i) begin
        if (!reset_n) begin
            r_s1     <= 1'b1;
            r_s2     <= 1'b1;
            r_s3     <= 1'b1;
            r_rx_st  <= S_IDLE;
            r_rx_tk  <= '0;
            r_rx_bit <= '0;
            r_rx_sh  <= '0;
        end else begin
            r_s1    <= rxd_i;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_rx_st <= w_rx_nx;
            if (r_rx_st == S_IDLE) r_rx_tk <= '0;
            else if (w_tick)       r_rx_tk <= r_rx_tk + 4'd1;
            if (r_rx_st == S_START) r_rx_bit <= '0;
            if (r_rx_st == S_DATA && w_rx_mid) begin
                r_rx_sh  <= {r_s2, r_rx_sh[7:1]};
                r_rx_bit <= r_rx_bit + 3'd1;
            end
        end
    end

    // Registers and status flags; set beats clear in one cycle
    always_ff @(posedge clk_logic_i) begin
        if (!reset_n) begin
            r_cmd  <= '0;
            r_ctrl <= '0;
            r_last <= '0;
            r_ovr  <= 1'b0;
            r_frm  <= 1'b0;
            r_txe  <= 1'b0;
        end else begin
            if (w_wr_cmd) r_cmd  <= bus.data_i;
            if (w_wr_ctl) r_ctrl <= bus.data_i;
            if (w_wr_sts) r_cmd[4:0] <= '0;
            if (w_rx_pop) r_last <= r_rxm[r_rx_rp];
            if (w_rx_pop | w_wr_sts) begin
                r_ovr <= 1'b0;
                r_frm <= 1'b0;
            end
            if (w_rx_push & ~w_rx_ok & ~w_wr_sts) r_ovr <= 1'b1;
            if (w_rx_push & ~r_s2 & ~w_wr_sts)    r_frm <= 1'b1;
            if (w_rd_sts | w_wr_dat) r_txe <= 1'b0;
            if (w_tx_pop & ~w_wr_dat & (r_tx_cnt == TCW'(1)))
                r_txe <= 1'b1;
        end
    end

`ifdef ACIA_AUTO_FLOW_EN
    logic r_rts_hold;
    always_ff @(posedge clk_logic_i) begin
        if (!reset_n)
            r_rts_hold <= 1'b0;
        else if (r_rx_cnt >= RCW'(RX_DEPTH - 2))
            r_rts_hold <= 1'b1;
        else if (r_rx_cnt < RCW'(RX_DEPTH - 4))
            r_rts_hold <= 1'b0;
    end
    assign rts_n_o = r_rts_hold | (r_cmd[3:2] == 2'b00);
`else
    assign rts_n_o = (r_cmd[3:2] == 2'b00);
`endif

    assign dtr_n_o = ~r_cmd[0];
    assign w_irq = (~r_cmd[1] & (r_rx_cnt >= RCW'(RX_IRQ_LEVEL)))
                 | ((r_cmd[3:2] == 2'b01) & r_txe);
    assign bus.irq_n_o = ~w_irq;
    assign rx_level_o  = r_rx_cnt;
    assign tx_level_o  = r_tx_cnt;

    always_comb begin
        bus.data_o = '0;
        unique case (bus.rs_i)
            2'd0: bus.data_o = w_rx_empty ? r_last : r_rxm[r_rx_rp];
            2'd1: bus.data_o = {w_irq, ~dsr_n_i, ~dcd_n_i, ~w_tx_full,
                                ~w_rx_empty, r_ovr, r_frm, 1'b0};
            2'd2: bus.data_o = r_cmd;
            2'd3: bus.data_o = r_ctrl;
            default: bus.data_o = '0;
        endcase
    end
endmodule

// File: tb/tb_acia_fifo_uart.sv
// Directed bench for acia_fifo_uart at 9600 baud, divisor 2.
// One bit = 32 clocks, one frame = 320 clocks.
module tb_acia_fifo_uart;
    logic       clk, rst_n;
    logic       txd, rxd, tb_rxd, lb;
    logic       cts_n, dcd_n, dsr_n, rts_n, dtr_n;
    logic [4:0] rx_level, tx_level;
    int         tests, fails;

    acia_fifo_uart_if bus_if ();

    assign rxd = lb ? txd : tb_rxd;

    acia_fifo_uart #(
        .CLOCK_SPEED_HZ(307200),
        .RX_DEPTH(16),
        .TX_DEPTH(16),
        .RX_IRQ_LEVEL(4)
    ) dut (
        .clk_logic_i(clk),
        .reset_n(rst_n),
        .bus(bus_if),
        .rxd_i(rxd),
        .txd_o(txd),
        .cts_n_i(cts_n),
        .dcd_n_i(dcd_n),
        .dsr_n_i(dsr_n),
        .rts_n_o(rts_n),
        .dtr_n_o(dtr_n),
        .rx_level_o(rx_level),
        .tx_level_o(tx_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic bus_op(input logic rw, input logic [1:0] rs,
                          input logic [7:0] d, output logic [7:0] q);
        @(posedge clk); #1;
        bus_if.ph2_i  = 1'b1;
        bus_if.cs_i   = 1'b1;
        bus_if.rw_n_i = rw;
        bus_if.rs_i   = rs;
        bus_if.data_i = d;
        @(negedge clk);
        q = bus_if.data_o;
        @(posedge clk); #1;
        bus_if.ph2_i  = 1'b0;
        bus_if.cs_i   = 1'b0;
        bus_if.rw_n_i = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tb_rxd = 1'b0;
        repeat (32) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 tb_rxd = b[i];
            repeat (32) @(posedge clk);
        end
        #1 tb_rxd = 1'b1;
        repeat (40) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] q;
        @(negedge clk);
        tests++; if (txd !== 1'b1) begin fails++;
            $display("FAIL reset_txd got %b want 1", txd); end
        tests++; if (bus_if.irq_n_o !== 1'b1) begin fails++;
            $display("FAIL reset_irq got %b want 1", bus_if.irq_n_o); end
        tests++; if ({rts_n, dtr_n} !== 2'b11) begin fails++;
            $display("FAIL reset_rts_dtr got %b want 11", {rts_n, dtr_n}); end
        tests++; if ({rx_level, tx_level} !== 10'd0) begin fails++;
            $display("FAIL reset_levels got %0d/%0d want 0/0",
                     rx_level, tx_level); end
        bus_op(1'b1, 2'd1, 8'h00, q);
        tests++; if (q !== 8'h10) begin fails++;
            $display("FAIL reset_status got %h want 10", q); end
        bus_op(1'b1, 2'd2, 8'h00, q);
        tests++; if (q !== 8'h00) begin fails++;
            $display("FAIL reset_cmd got %h want 00", q); end
        bus_op(1'b1, 2'd3, 8'h00, q);
        tests++; if (q !== 8'h00) begin fails++;
            $display("FAIL reset_ctrl got %h want 00", q); end
    endtask

    task automatic test_tx_frame();
        logic [7:0] q, pat;
        int n, lowc, highc;
        logic e;
        pat = 8'h55;
        bus_op(1'b0, 2'd3, 8'h0E, q);
        bus_op(1'b0, 2'd2, 8'h0B, q);
        @(negedge clk);
        tests++; if ({rts_n, dtr_n} !== 2'b00) begin fails++;
            $display("FAIL tx_modem got %b want 00", {rts_n, dtr_n}); end
        bus_op(1'b0, 2'd0, 8'h55, q);
        n = 0;
        while (txd !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        tests++; if (n >= 200) begin fails++;
            $display("FAIL tx_start_timeout got %0d want <200", n); end
        lowc = 1;
        @(negedge clk);
        while (txd === 1'b0 && lowc < 100) begin lowc++; @(negedge clk); end
        tests++; if (lowc != 31 && lowc != 32) begin fails++;
            $display("FAIL tx_start_len got %0d want 31..32", lowc); end
        highc = 1;
        @(negedge clk);
        while (txd === 1'b1 && highc < 100) begin highc++; @(negedge clk); end
        tests++; if (highc != 32) begin fails++;
            $display("FAIL tx_bit0_len got %0d want 32", highc); end
        for (int i = 1; i <= 8; i++) begin
            repeat ((i == 1) ? 15 : 32) @(negedge clk);
            e = (i == 8) ? 1'b1 : pat[i];
            tests++; if (txd !== e) begin fails++;
                $display("FAIL tx_bit%0d got %b want %b", i, txd, e); end
        end
        repeat (40) @(negedge clk);
        tests++; if (txd !== 1'b1 || tx_level !== 5'd0) begin fails++;
            $display("FAIL tx_idle got %b/%0d want 1/0", txd, tx_level); end
    endtask

    task automatic test_loopback();
        logic [7:0] q;
        int n;
        lb = 1'b1;
        for (int i = 0; i < 16; i++) bus_op(1'b0, 2'd0, 8'(i), q);
        n = 0;
        while (rx_level !== 5'd16 && n < 8000) begin @(negedge clk); n++; end
        tests++; if (rx_level !== 5'd16) begin fails++;
            $display("FAIL lb_level got %0d want 16", rx_level); end
        bus_op(1'b1, 2'd1, 8'h00, q);
        tests++; if (q !== 8'h18) begin fails++;
            $display("FAIL lb_status_full got %h want 18", q); end
        for (int i = 0; i < 16; i++) begin
            bus_op(1'b1, 2'd0, 8'h00, q);
            tests++; if (q !== 8'(i)) begin fails++;
                $display("FAIL lb_data%0d got %h want %h", i, q, 8'(i)); end
        end
        bus_op(1'b1, 2'd1, 8'h00, q);
        tests++; if (q !== 8'h10) begin fails++;
            $display("FAIL lb_status_empty got %h want 10", q); end
        repeat (20) @(negedge clk);
        lb = 1'b0;
    endtask

    task automatic test_overrun();
        logic [7:0] q;
        for (int i = 0; i < 17; i++) send_byte(8'hA0 + 8'(i));
        @(negedge clk);
        tests++; if (rx_level !== 5'd16) begin fails++;
            $display("FAIL ovr_level got %0d want 16", rx_level); end
        bus_op(1'b1, 2'd1, 8'h00, q);
        tests++; if (q !== 8'h1C) begin fails++;
            $display("FAIL ovr_status got %h want 1C", q); end
        bus_op(1'b1, 2'd0, 8'h00, q);
        tests++; if (q !== 8'hA0) begin fails++;
            $display("FAIL ovr_first got %h want A0", q); end
        bus_op(1'b1, 2'd1, 8'h00, q);
        tests++; if (q !== 8'h18) begin fails++;
            $display("FAIL ovr_cleared got %h want 18", q); end
        for (int i = 1; i < 16; i++) begin
            bus_op(1'b1, 2'd0, 8'h00, q);
            tests++; if (q !== 8'hA0 + 8'(i)) begin fails++;
                $display("FAIL ovr_data%0d got %h want %h",
                         i, q, 8'hA0 + 8'(i)); end
        end
        bus_op(1'b1, 2'd0, 8'h00, q);
        @(negedge clk);
        tests++; if (q !== 8'hAF || rx_level !== 5'd0) begin fails++;
            $display("FAIL ovr_empty_read got %h/%0d want AF/0",
                     q, rx_level); end
    endtask

    task automatic test_framing();
        logic [7:0] q;
        tb_rxd = 1'b0;
        repeat (12 * 32) @(posedge clk);
        #1 tb_rxd = 1'b1;
        repeat (40) @(negedge clk);
        tests++; if (rx_level !== 5'd1) begin fails++;
            $display("FAIL frm_level got %0d want 1", rx_level); end
        bus_op(1'b1, 2'd1, 8'h00, q);
        tests++; if (q !== 8'h1A) begin fails++;
            $display("FAIL frm_status got %h want 1A", q); end
        bus_op(1'b1, 2'd0, 8'h00, q);
        tests++; if (q !== 8'h00) begin fails++;
            $display("FAIL frm_data got %h want 00", q); end
        bus_op(1'b1, 2'd1, 8'h00, q);
        tests++; if (q !== 8'h10) begin fails++;
            $display("FAIL frm_cleared got %h want 10", q); end
        @(posedge clk); #1 tb_rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1 tb_rxd = 1'b1;
        repeat (400) @(negedge clk);
        tests++; if (rx_level !== 5'd0) begin fails++;
            $display("FAIL glitch_level got %0d want 0", rx_level); end
    endtask

    task automatic test_irq();
        logic [7:0] q;
        bus_op(1'b0, 2'd2, 8'h09, q);
        for (int i = 0; i < 3; i++) send_byte(8'h30 + 8'(i));
        @(negedge clk);
        tests++; if (bus_if.irq_n_o !== 1'b1 || rx_level !== 5'd3) begin
            fails++;
            $display("FAIL irq_3bytes got %b/%0d want 1/3",
                     bus_if.irq_n_o, rx_level); end
        send_byte(8'h33);
        @(negedge clk);
        tests++; if (bus_if.irq_n_o !== 1'b0) begin fails++;
            $display("FAIL irq_4bytes got %b want 0", bus_if.irq_n_o); end
        bus_op(1'b1, 2'd1, 8'h00, q);
        tests++; if (q !== 8'h98) begin fails++;
            $display("FAIL irq_status got %h want 98", q); end
        bus_op(1'b1, 2'd0, 8'h00, q);
        @(negedge clk);
        tests++; if (bus_if.irq_n_o !== 1'b1 || q !== 8'h30) begin fails++;
            $display("FAIL irq_level3 got %b/%h want 1/30",
                     bus_if.irq_n_o, q); end
        for (int i = 0; i < 3; i++) bus_op(1'b1, 2'd0, 8'h00, q);
        bus_op(1'b0, 2'd2, 8'h05, q);
        @(negedge clk);
        tests++; if (bus_if.irq_n_o !== 1'b1) begin fails++;
            $display("FAIL txirq_idle got %b want 1", bus_if.irq_n_o); end
        bus_op(1'b0, 2'd0, 8'h3C, q);
        repeat (4) @(negedge clk);
        tests++; if (bus_if.irq_n_o !== 1'b0) begin fails++;
            $display("FAIL txirq_set got %b want 0", bus_if.irq_n_o); end
        bus_op(1'b1, 2'd1, 8'h00, q);
        @(negedge clk);
        tests++; if (q !== 8'h90 || bus_if.irq_n_o !== 1'b1) begin fails++;
            $display("FAIL txirq_clear got %h/%b want 90/1",
                     q, bus_if.irq_n_o); end
        repeat (400) @(negedge clk);
    endtask

    task automatic test_prog_reset();
        logic [7:0] q;
        bus_op(1'b0, 2'd2, 8'h0B, q);
        for (int i = 0; i < 6; i++) bus_op(1'b0, 2'd0, 8'h00, q);
        @(negedge clk);
        tests++; if (tx_level !== 5'd5) begin fails++;
            $display("FAIL pr_queued got %0d want 5", tx_level); end
        repeat (100) @(negedge clk);
        bus_op(1'b0, 2'd1, 8'hFF, q);
        @(negedge clk);
        tests++; if (tx_level !== 5'd0 || dtr_n !== 1'b1 || rts_n !== 1'b1)
        begin fails++;
            $display("FAIL pr_flush got %0d/%b/%b want 0/1/1",
                     tx_level, dtr_n, rts_n); end
        bus_op(1'b1, 2'd2, 8'h00, q);
        tests++; if (q !== 8'h00) begin fails++;
            $display("FAIL pr_cmd got %h want 00", q); end
        bus_op(1'b1, 2'd3, 8'h00, q);
        tests++; if (q !== 8'h0E) begin fails++;
            $display("FAIL pr_ctrl got %h want 0E", q); end
        repeat (40) @(negedge clk);
        tests++; if (txd !== 1'b0) begin fails++;
            $display("FAIL pr_inflight got %b want 0", txd); end
        repeat (250) @(negedge clk);
        tests++; if (txd !== 1'b1 || tx_level !== 5'd0) begin fails++;
            $display("FAIL pr_done got %b/%0d want 1/0", txd, tx_level); end
    endtask

    task automatic test_hw_reset();
        logic [7:0] q;
        bus_op(1'b0, 2'd0, 8'h00, q);
        repeat (60) @(negedge clk);
        tests++; if (txd !== 1'b0) begin fails++;
            $display("FAIL hw_midframe got %b want 0", txd); end
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests++; if (txd !== 1'b1 || dtr_n !== 1'b1 ||
                     bus_if.irq_n_o !== 1'b1) begin fails++;
            $display("FAIL hw_abort got %b/%b/%b want 1/1/1",
                     txd, dtr_n, bus_if.irq_n_o); end
        #1 rst_n = 1'b1;
        bus_op(1'b1, 2'd3, 8'h00, q);
        tests++; if (q !== 8'h00) begin fails++;
            $display("FAIL hw_ctrl got %h want 00", q); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        lb = 1'b0;
        tb_rxd = 1'b1;
        cts_n = 1'b0;
        dcd_n = 1'b1;
        dsr_n = 1'b1;
        bus_if.ph2_i  = 1'b0;
        bus_if.cs_i   = 1'b0;
        bus_if.rw_n_i = 1'b1;
        bus_if.rs_i   = 2'd0;
        bus_if.data_i = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_tx_frame();
        test_loopback();
        test_overrun();
        test_framing();
        test_irq();
        test_prog_reset();
        test_hw_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
